// File: rtl/div_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
package div_mon_pkg;

    typedef enum logic [1:0] {IDLE, ARM, MEAS, LOCKED} div_mon_state_t;

    // High time is acceptable at either side of N/2, so odd N tolerates one cycle of skew.
    function automatic logic duty_ok(input logic [31:0] n, input logic [31:0] hi);
        return (hi == (n >> 1)) || (hi == ((n + 32'd1) >> 1));
    endfunction

endpackage

// File: rtl/div_mon_edge_det.sv
// Rising-edge detector for the monitored divided clock.
// Optional two-flop synchroniser on the input when DIV_MON_SYNC_EN is defined.
module div_mon_edge_det
    import div_mon_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clk_div_in,
    output logic samp,
    output logic rise
);

    logic prev;

`ifdef DIV_MON_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= 2'b00;
        else     sync <= {sync[0], clk_div_in};
    end

    assign samp = sync[1];
`else
    assign samp = clk_div_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= samp;
    end

    assign rise = samp & ~prev;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures period and high time of a divided clock in clk cycles and checks them against expected_div.
// Define DIV_MON_SYNC_EN to synchronise clk_div_in when it is not launched from clk.
module div_clk_monitor
    import div_mon_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clk_div_in,
    input  logic [CNT_W-1:0] expected_div,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             meas_valid,
    output logic             locked,
    output logic             err_period,
    output logic             err_duty,
    output logic             err_timeout
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [GW-1:0]    G_ONE   = 1;

    logic samp, rise;

    div_mon_edge_det u_edge (
        .clk        (clk),
        .rst        (rst),
        .clk_div_in (clk_div_in),
        .samp       (samp),
        .rise       (rise)
    );

    div_mon_state_t   state, state_nxt;
    logic [CNT_W-1:0] per_cnt, hi_cnt;
    logic [GW-1:0]    good_cnt;
    logic             active, do_meas, per_bad, duty_bad, good, timeout, lock_hit;

    always_comb begin
        active   = (state != IDLE);
        do_meas  = enable && rise && (state == MEAS || state == LOCKED);
        per_bad  = (per_cnt != expected_div);
        duty_bad = !duty_ok(32'(expected_div), 32'(hi_cnt));
        good     = !per_bad && !duty_bad;
        // A rise on the saturating cycle is still a (bad) measurement, not a timeout.
        timeout  = enable && active && !rise && (per_cnt == CNT_MAX);
        lock_hit = good && (int'(good_cnt) + 1 >= LOCK_CNT);

        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARM;
                ARM:     if (!timeout && rise) state_nxt = MEAS;
                MEAS:    if (timeout) state_nxt = ARM;
                         else if (do_meas && lock_hit) state_nxt = LOCKED;
                LOCKED:  if (timeout) state_nxt = ARM;
                         else if (do_meas && !good) state_nxt = MEAS;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt     <= '0;
            hi_cnt      <= '0;
            good_cnt    <= '0;
            meas_period <= '0;
            meas_high   <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            err_period  <= 1'b0;
            err_duty    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            meas_valid  <= 1'b0;
            err_period  <= 1'b0;
            err_duty    <= 1'b0;
            err_timeout <= 1'b0;
            if (!enable) begin
                per_cnt     <= '0;
                hi_cnt      <= '0;
                good_cnt    <= '0;
                locked      <= 1'b0;
                meas_period <= '0;
                meas_high   <= '0;
            end else if (!active) begin
                per_cnt <= '0;
                hi_cnt  <= '0;
            end else if (timeout) begin
                err_timeout <= 1'b1;
                locked      <= 1'b0;
                good_cnt    <= '0;
                per_cnt     <= '0;
                hi_cnt      <= '0;
            end else begin
                if (rise) begin
                    per_cnt <= CNT_ONE;
                    hi_cnt  <= {{(CNT_W-1){1'b0}}, samp};
                end else begin
                    if (per_cnt != CNT_MAX)          per_cnt <= per_cnt + CNT_ONE;
                    if (samp && hi_cnt != CNT_MAX)   hi_cnt  <= hi_cnt + CNT_ONE;
                end
                if (do_meas) begin
                    meas_period <= per_cnt;
                    meas_high   <= hi_cnt;
                    meas_valid  <= 1'b1;
                    err_period  <= per_bad;
                    err_duty    <= duty_bad;
                    if (!good) begin
                        good_cnt <= '0;
                        locked   <= 1'b0;
                    end else if (state == MEAS) begin
                        good_cnt <= good_cnt + G_ONE;
                        if (lock_hit) locked <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
